// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: opcode map, ALU/PC select
// codes, FSM state encoding and the bundled control word.
package ctrl_pkg;

  localparam logic [5:0] OP_LW  = 6'b000000;
  localparam logic [5:0] OP_SW  = 6'b000001;
  localparam logic [5:0] OP_BEQ = 6'b001011;
  localparam logic [5:0] OP_BNE = 6'b001100;
  localparam logic [5:0] OP_J   = 6'b001101;

  typedef enum logic [1:0] {
    ALU_FUNC = 2'b00,
    ALU_CMP  = 2'b01,
    ALU_ADD  = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10
  } pc_src_e;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_WB_MEM = 4'd6,
    S_MEM_WR = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_e;

  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jump;
    logic is_rtype;
  } op_class_t;

  typedef struct packed {
    logic    imem_req;
    logic    ir_write;
    logic    pc_write;
    pc_src_e pc_src;
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    instr_done;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_opcode_class_decode.sv
// Opcode classifier: exactly one class bit is set; anything not in the
// memory/branch/jump map is treated as data processing.
module opcode_class_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_LW:          cls.is_load   = 1'b1;
      OP_SW:          cls.is_store  = 1'b1;
      OP_BEQ, OP_BNE: cls.is_branch = 1'b1;
      OP_J:           cls.is_jump   = 1'b1;
      default:        cls.is_rtype  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer: steps the shared datapath through
// fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_dbg
);

  state_e     state, nxt;
  logic [5:0] op_q;
  op_class_t  cls;
  ctrl_t      c;

  opcode_class_decode u_cls (
    .opcode (opcode),
    .cls    (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= nxt;
  end

  // Opcode is only guaranteed during DECODE; later states use the latched copy.
  always_ff @(posedge clk) begin
    if (reset)                 op_q <= '0;
    else if (state == S_DECODE) op_q <= opcode;
  end

  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:  nxt = imem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (1'b1)
          cls.is_load, cls.is_store: nxt = S_ADDR;
          cls.is_branch:             nxt = S_BRANCH;
          cls.is_jump:               nxt = S_JUMP;
          cls.is_rtype:              nxt = S_EXEC_R;
          default:                   nxt = S_EXEC_R;
        endcase
      end
      S_EXEC_R: nxt = S_WB_R;
      S_WB_R:   nxt = S_FETCH;
      S_ADDR:   nxt = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: nxt = dmem_ready ? S_WB_MEM : S_MEM_RD;
      S_WB_MEM: nxt = S_FETCH;
      S_MEM_WR: nxt = dmem_ready ? S_FETCH : S_MEM_WR;
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.imem_req = 1'b1;
        if (imem_ready) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          c.pc_src   = PC_INC;
        end
      end
      S_EXEC_R: begin
        c.alu_op  = ALU_FUNC;
        c.alu_src = 1'b0;
      end
      S_WB_R: begin
        c.alu_op     = ALU_FUNC;
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_ADDR: begin
        c.alu_op  = ALU_ADD;
        c.alu_src = 1'b1;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.alu_op   = ALU_ADD;
        c.alu_src  = 1'b1;
      end
      S_WB_MEM: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write  = 1'b1;
        c.alu_op     = ALU_ADD;
        c.alu_src    = 1'b1;
        c.instr_done = dmem_ready;
      end
      S_BRANCH: begin
        c.alu_op     = ALU_CMP;
        c.pc_src     = PC_BR;
        c.pc_write   = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
        c.instr_done = 1'b1;
      end
      S_JUMP: begin
        c.pc_src     = PC_JMP;
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset aborts the current step: no fetch, write or retire in that cycle.
    if (reset) c = '0;
  end

  always_ff @(posedge clk) begin
    if (reset)             instr_count <= '0;
    else if (c.instr_done) instr_count <= instr_count + CNT_W'(1);
  end

  assign imem_req   = c.imem_req;
  assign ir_write   = c.ir_write;
  assign pc_write   = c.pc_write;
  assign pc_src     = c.pc_src;
  assign alu_op     = c.alu_op;
  assign alu_src    = c.alu_src;
  assign reg_dst    = c.reg_dst;
  assign mem_to_reg = c.mem_to_reg;
  assign reg_write  = c.reg_write;
  assign mem_read   = c.mem_read;
  assign mem_write  = c.mem_write;
  assign instr_done = c.instr_done;
  assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench: each instruction is expanded into its expected cycle
// trace, replayed cycle by cycle and compared against the sequencer outputs.
module tb_multicycle_ctrl_fsm;

  localparam logic [5:0] LW  = 6'b000000;
  localparam logic [5:0] SW  = 6'b000001;
  localparam logic [5:0] BEQ = 6'b001011;
  localparam logic [5:0] BNE = 6'b001100;
  localparam logic [5:0] JMP = 6'b001101;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic        reset, zero, imem_ready, dmem_ready;
  logic [5:0]  opcode;
  logic        imem_req, ir_write, pc_write, alu_src, reg_dst, mem_to_reg;
  logic        reg_write, mem_read, mem_write, instr_done;
  logic [1:0]  pc_src, alu_op;
  logic [31:0] instr_count;
  logic [3:0]  state_dbg;

  logic        imem_req2, ir_write2, pc_write2, alu_src2, reg_dst2, mem_to_reg2;
  logic        reg_write2, mem_read2, mem_write2, instr_done2;
  logic [1:0]  pc_src2, alu_op2;
  logic [2:0]  instr_count2;
  logic [3:0]  state_dbg2;

  multicycle_ctrl_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .instr_done(instr_done), .instr_count(instr_count), .state_dbg(state_dbg)
  );

  // Narrow counter instance so modulo wrap is reached within a short run.
  multicycle_ctrl_fsm #(.CNT_W(3)) dut_w (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req2), .ir_write(ir_write2), .pc_write(pc_write2), .pc_src(pc_src2),
    .alu_op(alu_op2), .alu_src(alu_src2), .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2),
    .reg_write(reg_write2), .mem_read(mem_read2), .mem_write(mem_write2),
    .instr_done(instr_done2), .instr_count(instr_count2), .state_dbg(state_dbg2)
  );

  typedef struct packed {
    logic        rst, ir, dr, z;
    logic [5:0]  op;
    logic [13:0] exp;
    logic        chk;
    logic [31:0] cnt;
  } item_t;

  item_t       prog[$];
  item_t       cur;
  logic        cur_vld = 1'b0;
  int          cur_idx = 0;
  logic [31:0] mcnt = 0;
  logic        mknown = 1'b0;
  int          checks = 0, errors = 0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] ro();
    return 6'($urandom);
  endfunction

  // {imem_req, ir_write, pc_write, pc_src, alu_op, alu_src, reg_dst,
  //  mem_to_reg, reg_write, mem_read, mem_write, instr_done}
  function automatic logic [13:0] mk(input logic ireq, irw, pcw, input logic [1:0] pcs, alu,
                                     input logic asrc, rdst, m2r, rw, mr, mw, done);
    return {ireq, irw, pcw, pcs, alu, asrc, rdst, m2r, rw, mr, mw, done};
  endfunction

  task automatic push(input logic rst, ir, dr, z, input logic [5:0] op, input logic [13:0] e);
    item_t it;
    it.rst = rst; it.ir = ir; it.dr = dr; it.z = z; it.op = op; it.exp = e;
    it.chk = mknown; it.cnt = mcnt;
    prog.push_back(it);
    if (rst) begin
      mcnt = 0; mknown = 1'b1;
    end else if (e[0]) mcnt = mcnt + 1;
  endtask

  task automatic push_rst();
    push(1'b1, rb(), rb(), rb(), ro(), 14'd0);
  endtask

  task automatic fetch(input int iw);
    for (int i = 0; i < iw; i++) push(1'b0, 1'b0, rb(), rb(), ro(), mk(1,0,0,2'd0,2'd0,0,0,0,0,0,0,0));
    push(1'b0, 1'b1, rb(), rb(), ro(), mk(1,1,1,2'd0,2'd0,0,0,0,0,0,0,0));
  endtask

  task automatic gen(input logic [5:0] op, input int iw, input int dw, input logic z, output int ncyc);
    int n0;
    n0 = prog.size();
    fetch(iw);
    push(1'b0, rb(), rb(), rb(), op, 14'd0);
    if (op == LW) begin
      push(1'b0, rb(), rb(), rb(), ro(), mk(0,0,0,2'd0,2'd2,1,0,0,0,0,0,0));
      for (int i = 0; i < dw; i++) push(1'b0, rb(), 1'b0, rb(), ro(), mk(0,0,0,2'd0,2'd2,1,0,0,0,1,0,0));
      push(1'b0, rb(), 1'b1, rb(), ro(), mk(0,0,0,2'd0,2'd2,1,0,0,0,1,0,0));
      push(1'b0, rb(), rb(), rb(), ro(), mk(0,0,0,2'd0,2'd0,0,0,1,1,0,0,1));
    end else if (op == SW) begin
      push(1'b0, rb(), rb(), rb(), ro(), mk(0,0,0,2'd0,2'd2,1,0,0,0,0,0,0));
      for (int i = 0; i < dw; i++) push(1'b0, rb(), 1'b0, rb(), ro(), mk(0,0,0,2'd0,2'd2,1,0,0,0,0,1,0));
      push(1'b0, rb(), 1'b1, rb(), ro(), mk(0,0,0,2'd0,2'd2,1,0,0,0,0,1,1));
    end else if (op == BEQ || op == BNE) begin
      push(1'b0, rb(), rb(), z, ro(), mk(0,0,(op == BEQ) ? z : !z,2'd1,2'd1,0,0,0,0,0,0,1));
    end else if (op == JMP) begin
      push(1'b0, rb(), rb(), rb(), ro(), mk(0,0,1,2'd2,2'd0,0,0,0,0,0,0,1));
    end else begin
      push(1'b0, rb(), rb(), rb(), ro(), 14'd0);
      push(1'b0, rb(), rb(), rb(), ro(), mk(0,0,0,2'd0,2'd0,0,1,0,1,0,0,1));
    end
    ncyc = prog.size() - n0;
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Per-cycle comparison against the expanded expectation.
  always @(negedge clk) begin
    if (cur_vld) begin
      logic [13:0] act;
      act = {imem_req, ir_write, pc_write, pc_src, alu_op, alu_src, reg_dst,
             mem_to_reg, reg_write, mem_read, mem_write, instr_done};
      checks++;
      if (act !== cur.exp) begin
        errors++;
        $display("FAIL ctrl cycle %0d actual=%b required=%b", cur_idx, act, cur.exp);
      end
      if (cur.chk) begin
        checks++;
        if (instr_count !== cur.cnt) begin
          errors++;
          $display("FAIL count cycle %0d actual=%0d required=%0d", cur_idx, instr_count, cur.cnt);
        end
        checks++;
        if (instr_count2 !== cur.cnt[2:0]) begin
          errors++;
          $display("FAIL count_wrap cycle %0d actual=%0d required=%0d", cur_idx, instr_count2, cur.cnt[2:0]);
        end
      end
    end
  end

  initial begin
    int n, dir_end, abort_end, sel;
    logic [5:0] op;

    // Directed section.
    push(1'b1, 1'b1, 1'b0, 1'b0, ro(), 14'd0);
    push(1'b1, 1'b1, 1'b0, 1'b0, ro(), 14'd0);
    gen(6'b000010, 0, 0, 1'b0, n); lit("len_rtype", n, 4);
    gen(LW, 0, 3, 1'b0, n);        lit("len_lw_3wait", n, 8);
    gen(BEQ, 0, 0, 1'b1, n);       lit("len_beq", n, 3);
    gen(BNE, 0, 0, 1'b1, n);
    gen(JMP, 0, 0, 1'b0, n);       lit("len_j", n, 3);
    gen(6'b001010, 0, 0, 1'b0, n); lit("len_op0a", n, 4);
    gen(SW, 1, 0, 1'b0, n);        lit("len_sw_1iwait", n, 5);
    lit("model_count_dir", mcnt, 7);
    dir_end = prog.size();

    // SW aborted by reset while waiting on dmem_ready.
    fetch(0);
    push(1'b0, rb(), rb(), rb(), SW, 14'd0);
    push(1'b0, rb(), rb(), rb(), ro(), mk(0,0,0,2'd0,2'd2,1,0,0,0,0,0,0));
    push(1'b0, rb(), 1'b0, rb(), ro(), mk(0,0,0,2'd0,2'd2,1,0,0,0,0,1,0));
    push(1'b1, rb(), 1'b0, rb(), ro(), 14'd0);
    abort_end = prog.size();

    // Randomized section.
    repeat (250) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: op = LW;
        1: op = SW;
        2: op = BEQ;
        3: op = BNE;
        4: op = JMP;
        default: op = ro();
      endcase
      gen(op, $urandom_range(0, 2), $urandom_range(0, 3), rb(), n);
      if ($urandom_range(0, 24) == 0) push_rst();
    end

    for (int i = 0; i < prog.size(); i++) begin
      reset      = prog[i].rst;
      imem_ready = prog[i].ir;
      dmem_ready = prog[i].dr;
      zero       = prog[i].z;
      opcode     = prog[i].op;
      if (i == dir_end) begin
        lit("dut_count_dir", instr_count, 7);
        lit("dut_wrap_dir", {29'd0, instr_count2}, 7);
      end
      if (i == abort_end) lit("dut_count_abort", instr_count, 0);
      cur     = prog[i];
      cur_idx = i;
      cur_vld = 1'b1;
      @(posedge clk);
      #1;
    end
    cur_vld = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle sequencer for the 32-bit core; replaces single-cycle decode with a state machine that steps the shared datapath (PC, IR, ALU, register file, memories) through fetch/decode/execute/memory/writeback.
- Uses the existing opcode map and alu_op encoding.
- Stalls on instruction- and data-memory ready handshakes.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- zero  in  1  ALU zero flag
- imem_ready  in  1  instruction memory ack; IR data valid this cycle
- dmem_ready  in  1  data memory ack for current read or write
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load IR
- pc_write  out  1  PC update enable
- pc_src  out  2  00 PC+1, 01 branch target, 10 jump target
- alu_op  out  2  00 function/data-processing, 01 compare (subtract), 10 address add
- alu_src  out  1  1 = immediate operand
- reg_dst  out  1  1 = rd destination, 0 = rt destination
- mem_to_reg  out  1  1 = writeback from memory
- reg_write  out  1  register file write enable
- mem_read  out  1  data memory read request
- mem_write  out  1  data memory write request
- instr_done  out  1  one-cycle pulse on instruction retirement
- instr_count  out  CNT_W  retired-instruction count
- state_dbg  out  4  current state encoding

Behaviour:
- States: FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP.
- Reset:
  - state <= FETCH, op_q <= 0, instr_count <= 0.
  - While reset is high, all enables/requests (imem_req, ir_write, pc_write, reg_write, mem_read, mem_write, instr_done) are forced 0.
  - pc_src, alu_op, alu_src, reg_dst, mem_to_reg = 0.
  - Reset mid-instruction aborts with no register or memory write in that cycle.
- FETCH:
  - imem_req = 1.
  - When imem_ready: ir_write = 1, pc_write = 1, pc_src = 00, next DECODE.
  - Otherwise hold FETCH with ir_write = pc_write = 0.
- DECODE:
  - op_q <= opcode. Next state from opcode:
  - 000000 → ADDR (LW)
  - 000001 → ADDR (SW)
  - 001011 / 001100 → BRANCH
  - 001101 → JUMP
  - 000010–001001 and every other value, including 001010 and 001110–111111 → EXEC_R (default is data processing).
- EXEC_R: alu_op = 00, alu_src = 0. Next WB_R.
- WB_R: reg_dst = 1, mem_to_reg = 0, reg_write = 1, alu_op = 00; retire. Next FETCH.
- ADDR: alu_op = 10, alu_src = 1. Next MEM_RD if op_q = LW, else MEM_WR.
- MEM_RD:
  - mem_read = 1, alu_op = 10, alu_src = 1, held until dmem_ready.
  - On dmem_ready, next WB_MEM.
- WB_MEM: reg_dst = 0, mem_to_reg = 1, reg_write = 1; retire. Next FETCH.
- MEM_WR:
  - mem_write = 1, alu_op = 10, alu_src = 1, held until dmem_ready.
  - On dmem_ready, retire. Next FETCH.
- BRANCH:
  - alu_op = 01, alu_src = 0, pc_src = 01.
  - pc_write = (op_q = BEQ & zero) | (op_q = BNE & ~zero).
  - Retire. Next FETCH.
- JUMP: pc_src = 10, pc_write = 1; retire. Next FETCH.
- Retire: instr_done = 1 for exactly that cycle; instr_count <= instr_count + 1, wrapping modulo 2^CNT_W.
- Outputs not listed for a state are 0.
- Outputs are combinational from state and op_q (Moore, except FETCH ready gating and BRANCH zero gating).
- Minimum latency with zero-wait memories:
  - R-type: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ/BNE/J: 3 cycles
- Each wait cycle on imem_ready/dmem_ready adds one cycle.
- Ready inputs asserted outside their wait state are ignored.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J)
  - alu_op codes (ALU_FUNC, ALU_CMP, ALU_ADD)
  - pc_src codes
  - 4-bit state encodings
- One sub-module is natural: opcode_class_decode, a combinational map opcode → {is_load, is_store, is_branch, is_jump, is_rtype}.
- The FSM, output decode and counter stay in the top.

Test Plan:
- Reset held 2 cycles, then released with imem_ready = 1 → outputs 0 during reset; first cycle after release state FETCH, imem_req = 1, ir_write = 1, pc_write = 1; instr_count = 0.
- Opcode 000010, all readies = 1 → reg_write = 1 with reg_dst = 1 in cycle 4; instr_done pulses once; instr_count = 1; back in FETCH at cycle 5.
- LW (000000) with dmem_ready low for 3 cycles in MEM_RD → mem_read held 4 cycles; WB_MEM has mem_to_reg = 1, reg_write = 1; total 8 cycles.
- BEQ with zero = 1, then BNE with zero = 1 → BEQ: pc_write = 1, pc_src = 01 in BRANCH; BNE: pc_write = 0; both retire and count increments by 2.
- J (001101), then opcode 001010 → J: pc_write = 1, pc_src = 10 in cycle 3; 001010 follows the R-type path with reg_write = 1.
- reset asserted in MEM_WR while dmem_ready = 0 → mem_write = 0 that cycle; next state FETCH; instr_count = 0; no instr_done. Separately, preload count to 2^32−1 and retire one instruction → instr_count wraps to 0.
